result_bcd_display: RTL and testbench
=====================================

Name: result_bcd_display

Overview:
- Downstream consumer of the ALU's 16-bit Result.
- Converts an unsigned binary value to five BCD digits using a sequential shift-add-3 (double-dabble) engine with a start/busy/done handshake.
- Holds the last converted value and drives two 7-segment digit outputs, selected by a digit-pair selector with optional leading-zero blanking.
- Runs on the 10 MHz system clock between the ALU and the board's Segment7 outputs.

Parameters:
- WIDTH, 16, binary input width; also the number of shift cycles.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH - 1.
- BLANK_LEADING, 1, when 1, digits above the most significant nonzero digit show blank; digit 0 is never blanked.

Ports:
- CLK_10M  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  conversion request; sampled only in IDLE.
- Value  input  WIDTH  unsigned binary operand; captured on the accepted Start edge.
- DigitSel  input  2  digit pair shown: 0 = digits 1:0, 1 = digits 3:2, 2 = digit 4 only, 3 = none.
- Busy  output  1  high while shifting.
- Done  output  1  one-cycle pulse when BCD updates.
- BCD  output  4*DIGITS  last completed result, digit 0 in bits [3:0].
- Segment7_0  output  8  lower digit of selected pair, {dp,g,f,e,d,c,b,a}, active-high.
- Segment7_1  output  8  upper digit of selected pair, same format.

Behaviour:
- Reset: when RST=1 at a clock edge, state goes to IDLE and Busy=0, Done=0, BCD=0, and the shift and work registers clear. This applies from any state. Reset mid-conversion aborts it with no Done pulse.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Start=1 at edge T0 loads shift_reg=Value, work=0, count=0, then enters SHIFT.
  - Start=0 holds IDLE.
- SHIFT, one step per cycle:
  - Each 4-bit work digit that is >=5 gets +3.
  - Then {work,shift_reg} shifts left by 1.
  - count increments; after the WIDTH-th step, go to DONE.
- DONE: BCD <= work, Done=1 for exactly this cycle, then IDLE.
- Timing:
  - Busy=1 in cycles T0+1 .. T0+WIDTH, i.e. 16 cycles at default.
  - Done=1 and BCD valid from cycle T0+WIDTH+1.
  - Busy=0 whenever Done=1.
- Start while in SHIFT or DONE is ignored, with no queueing. A held Start re-triggers on the first IDLE cycle after DONE.
- Value changes after capture have no effect.
- BCD holds its value until the next completed conversion or reset.
- Segment outputs are combinational from BCD, DigitSel and BLANK_LEADING (no added latency).
- Segment encoding:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, blank=0x00.
  - dp is always 0.
- Selector cases:
  - DigitSel=2: Segment7_1 is always 0x00.
  - DigitSel=3: both outputs are 0x00.
- Blanking, with BLANK_LEADING=1:
  - Digit k>0 is blank iff digits DIGITS-1..k are all zero.
  - Interior zeros are shown.
- Digit values above 9 cannot occur; if forced, display blank.

Test Plan:
- Reset with DigitSel=0 -> BCD=20'h00000, Busy=0, Done=0, Segment7_0=0x3F, Segment7_1=0x00.
- Start pulse with Value=1234 -> Busy high for 16 cycles, Done pulses once on cycle 17, BCD=20'h01234. Displays by DigitSel:
  - DigitSel=0 -> 0x66 / 0x4F.
  - DigitSel=1 -> 0x5B / 0x06.
  - DigitSel=2 -> 0x00 / 0x00.
- Value=65535 -> BCD=20'h65535. DigitSel=2 -> Segment7_0=0x7D. DigitSel=1 -> 0x6D / 0x6D.
- Start with Value=500, then Start pulses with Value=9 at Busy cycles 3 and 16 and in the DONE cycle -> all ignored, a single Done pulse, BCD=20'h00500. DigitSel=0 shows 0x3F / 0x3F (interior zeros kept).
- RST asserted during shift cycle 8 of Value=4321 -> next cycle Busy=0, no Done pulse ever, BCD=0. A new Start with Value=7 then gives BCD=20'h00007 after 17 cycles.
- Start held high continuously with Value=100 -> back-to-back conversions with Done every 18 cycles, BCD=20'h00100. DigitSel=1 -> Segment7_0=0x06, Segment7_1=0x00.

Source files
------------

// File: rtl/result_bcd_display.sv
// result_bcd_display: binary-to-BCD converter (shift-add-3) with a
// two-digit 7-segment display selector and optional leading-zero blanking.
//
// Ports:
//   CLK_10M     system clock, all state on rising edge
//   RST         synchronous active-high reset (aborts a running conversion)
//   Start       conversion request, only honoured in IDLE
//   Value       unsigned operand, captured when Start is accepted
//   DigitSel    pair shown: 0 = digits 1:0, 1 = digits 3:2, 2 = digit 4, 3 = none
//   Busy        high during the WIDTH shift cycles
//   Done        one-cycle pulse in the cycle BCD first shows a new result
//   BCD         last completed result, digit 0 in bits [3:0]
//   Segment7_0  lower digit of selected pair, {dp,g,f,e,d,c,b,a}, active-high
//   Segment7_1  upper digit of selected pair, same format
module result_bcd_display #(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  CLK_10M,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Value,
  input  logic [1:0]            DigitSel,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [7:0]            Segment7_0,
  output logic [7:0]            Segment7_1
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    shift_reg;
  logic [WIDTH-1:0]    shift_nxt;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] work_adj;
  logic [4*DIGITS-1:0] work_nxt;
  logic [CW-1:0]       count;
  logic                last_step;

  assign last_step = (count == CW'(WIDTH - 1));

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // combined {work, shift_reg} register left by one.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
    work_nxt  = {work_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE_ST;
        end
      end
      DONE_ST: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and datapath. BCD is loaded with the result of the last
  // shift step on the edge that enters DONE, so it is already valid in the
  // same cycle that Done pulses.
  always_ff @(posedge CLK_10M) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      work      <= '0;
      count     <= '0;
      BCD       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Start) begin
            shift_reg <= Value;
            work      <= '0;
            count     <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_nxt;
          work      <= work_nxt;
          count     <= count + CW'(1);
          if (last_step) begin
            BCD <= work_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // 7-segment encoding; non-decimal codes display blank
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  logic [7:0]        seg_d [DIGITS];
  logic [DIGITS-1:0] blank;
  logic              all_zero;
  int                lo_idx;

  // Leading-zero blanking: scan from the top digit down; a digit is blank
  // while every digit from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    all_zero = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (BCD[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && (k > 0) && all_zero;
    end
    for (int k = 0; k < DIGITS; k++) begin
      seg_d[k] = blank[k] ? 8'h00 : seg7(BCD[4*k +: 4]);
    end
  end

  // Pair selection; selector 2 shows only its lower digit, selector 3 nothing
  always_comb begin
    Segment7_0 = 8'h00;
    Segment7_1 = 8'h00;
    lo_idx     = 2 * int'(DigitSel);
    if (DigitSel != 2'd3) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i == lo_idx) begin
          Segment7_0 = seg_d[i];
        end
        if ((DigitSel < 2'd2) && (i == lo_idx + 1)) begin
          Segment7_1 = seg_d[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_result_bcd_display.sv
module tb_result_bcd_display;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic [1:0]  digit_sel;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [7:0]  seg0;
  logic [7:0]  seg1;

  int total = 0;
  int bad   = 0;

  result_bcd_display #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut (
    .CLK_10M    (clk),
    .RST        (rst),
    .Start      (start),
    .Value      (value),
    .DigitSel   (digit_sel),
    .Busy       (busy),
    .Done       (done),
    .BCD        (bcd),
    .Segment7_0 (seg0),
    .Segment7_1 (seg1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse Start for one cycle, then watch 30 cycles (cycle 1 = first after
  // the accepting edge) and check handshake timing and the result.
  task automatic conv(input logic [15:0] v, input logic [19:0] exp_bcd);
    int busy_n;
    int done_n;
    int done_c;
    int overlap;
    busy_n = 0; done_n = 0; done_c = -1; overlap = 0;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = ~v;
    for (int c = 1; c <= 30; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_c = c;
        if (busy) overlap++;
      end
      @(negedge clk);
    end
    chk("busy_cycles", busy_n, 16);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_c, 17);
    chk("busy_done_overlap", overlap, 0);
    chk("bcd", bcd, exp_bcd);
  endtask

  typedef struct {
    logic        do_conv;
    logic [15:0] value;
    logic [1:0]  sel;
    logic [19:0] exp_bcd;
    logic [7:0]  exp_s0;
    logic [7:0]  exp_s1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int done_n;
    int first_d;
    int second_d;
    int busy_n;

    vecs[0]  = '{1'b1, 16'd1234,  2'd0, 20'h01234, 8'h66, 8'h4F};
    vecs[1]  = '{1'b0, 16'd1234,  2'd1, 20'h01234, 8'h5B, 8'h06};
    vecs[2]  = '{1'b0, 16'd1234,  2'd2, 20'h01234, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 16'd1234,  2'd3, 20'h01234, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 16'd65535, 2'd2, 20'h65535, 8'h7D, 8'h00};
    vecs[5]  = '{1'b0, 16'd65535, 2'd1, 20'h65535, 8'h6D, 8'h6D};
    vecs[6]  = '{1'b0, 16'd65535, 2'd0, 20'h65535, 8'h6D, 8'h4F};
    vecs[7]  = '{1'b1, 16'd9,     2'd0, 20'h00009, 8'h6F, 8'h00};
    vecs[8]  = '{1'b0, 16'd9,     2'd1, 20'h00009, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 16'd10,    2'd0, 20'h00010, 8'h3F, 8'h06};
    vecs[10] = '{1'b1, 16'd40960, 2'd1, 20'h40960, 8'h09 ^ 8'h66, 8'h00};
    // 40960 -> digits 4,0,9,6,0: digit 2 = 9 (0x6F), digit 3 = 0 shown (0x3F)
    vecs[10].exp_s0 = 8'h6F;
    vecs[10].exp_s1 = 8'h3F;

    rst = 1'b1; start = 1'b0; value = 16'd0; digit_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 20'h00000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seg0", seg0, 8'h3F);
    chk("rst_seg1", seg1, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven conversions and display selection
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_conv) conv(vecs[i].value, vecs[i].exp_bcd);
      digit_sel = vecs[i].sel;
      #1;
      chk("tbl_bcd", bcd, vecs[i].exp_bcd);
      chk("tbl_seg0", seg0, vecs[i].exp_s0);
      chk("tbl_seg1", seg1, vecs[i].exp_s1);
    end

    // Starts during SHIFT (cycles 3, 16) and DONE (cycle 17) are ignored
    done_n = 0; busy_n = 0;
    @(negedge clk);
    start = 1'b1; value = 16'd500;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      start = (c == 3 || c == 16 || c == 17);
      value = 16'd9;
      @(negedge clk);
    end
    start = 1'b0;
    digit_sel = 2'd0;
    #1;
    chk("ign_busy_cycles", busy_n, 16);
    chk("ign_done_count", done_n, 1);
    chk("ign_bcd", bcd, 20'h00500);
    chk("ign_seg0", seg0, 8'h3F);
    chk("ign_seg1", seg1, 8'h3F);

    // Reset during shift cycle 8 aborts the conversion
    done_n = 0;
    @(negedge clk);
    start = 1'b1; value = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 8) chk("abort_busy_before", busy, 1);
      if (c == 9) chk("abort_busy_after", busy, 0);
      if (done) done_n++;
      rst = (c == 8);
      @(negedge clk);
    end
    rst = 1'b0;
    chk("abort_done_count", done_n, 0);
    chk("abort_bcd", bcd, 20'h00000);
    conv(16'd7, 20'h00007);

    // Held Start gives back-to-back conversions, Done every 18 cycles
    done_n = 0; first_d = -1; second_d = -1;
    @(negedge clk);
    start = 1'b1; value = 16'd100;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (first_d < 0) first_d = c;
        else if (second_d < 0) second_d = c;
      end
    end
    start = 1'b0;
    repeat (25) @(negedge clk);
    digit_sel = 2'd1;
    #1;
    chk("held_done_count", done_n, 3);
    chk("held_first_done", first_d, 17);
    chk("held_period", second_d - first_d, 18);
    chk("held_bcd", bcd, 20'h00100);
    chk("held_seg0", seg0, 8'h06);
    chk("held_seg1", seg1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
